dip_word_loader: RTL and testbench

Operator-entry controller for the DIP-switch/button front panel. It synchronizes and debounces the load button, then sequences NBYTES successive switch bytes into one wide word. It hands the word downstream over a valid/ready handshake and supplies the byte shown on the hex display driver. It sits between the raw board pins and whatever consumes operator-entered words, such as a program/data loader.

---
 rtl/dip_word_loader.sv | 121 ++++++++++++
 tb/tb_dip_word_loader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dip_word_loader.sv
// Purpose: synchronize/debounce the load button and pack NBYTES switch bytes into one word.
// Latency: DEBOUNCE_CYCLES+3 cycles from a clean button edge to the byte being captured.
// Backpressure: holds word/word_valid while word_ready is low; presses are dropped while full.
//
// Ports:
//   clk, rst    system clock; asynchronous active-high reset
//   btn, dip    raw button and switch byte from the panel (asynchronous to clk)
//   hex_val     byte for the hex display: live switches while collecting, last byte when full
//   byte_idx    bytes captured so far in the current word
//   word        assembled word, first-entered byte in the most significant position
//   word_valid  word complete and offered downstream
//   word_ready  downstream accepts the word when high together with word_valid
module dip_word_loader #(
   parameter int NBYTES          = 8,
   parameter int DEBOUNCE_CYCLES = 12000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          btn,
   input  logic [7:0]                    dip,
   output logic [7:0]                    hex_val,
   output logic [$clog2(NBYTES+1)-1:0]   byte_idx,
   output logic [8*NBYTES-1:0]           word,
   output logic                          word_valid,
   input  logic                          word_ready
);

   localparam int W  = 8 * NBYTES;
   localparam int BW = $clog2(NBYTES + 1);
   localparam int DW = $clog2(DEBOUNCE_CYCLES);

   typedef enum logic {COLLECT, FULL} state_t;

   state_t          state_q, state_d;
   logic            btn_m, btn_s;
   logic [7:0]      dip_m, dip_s;
   logic            btn_db;
   logic [DW-1:0]   deb_cnt;
   logic            press;
   logic [W-1:0]    word_d;
   logic [BW-1:0]   byte_idx_d;

   // Two-flop synchronizers for the button and every switch bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_m <= 1'b0;
         btn_s <= 1'b0;
         dip_m <= '0;
         dip_s <= '0;
      end else begin
         btn_m <= btn;
         btn_s <= btn_m;
         dip_m <= dip;
         dip_s <= dip_m;
      end
   end

   // Debouncer: a level change is accepted only after it has been stable for
   // DEBOUNCE_CYCLES synchronized cycles. press is registered together with the
   // btn_db update so it is high exactly in the cycle after btn_db rises.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_db  <= 1'b0;
         deb_cnt <= '0;
         press   <= 1'b0;
      end else begin
         press <= 1'b0;
         if (btn_s == btn_db) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
            btn_db  <= btn_s;
            deb_cnt <= '0;
            press   <= btn_s;
         end else begin
            deb_cnt <= deb_cnt + DW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= COLLECT;
         word     <= '0;
         byte_idx <= '0;
      end else begin
         state_q  <= state_d;
         word     <= word_d;
         byte_idx <= byte_idx_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      word_d     = word;
      byte_idx_d = byte_idx;
      word_valid = 1'b0;
      hex_val    = dip_s;
      case (state_q)
         COLLECT: begin
            if (press) begin
               // Shift left one byte; the truncating cast also covers NBYTES == 1.
               word_d     = W'({word, dip_s});
               byte_idx_d = byte_idx + BW'(1);
               if (byte_idx_d == BW'(NBYTES))
                  state_d = FULL;
            end
         end
         FULL: begin
            word_valid = 1'b1;
            hex_val    = word[7:0];
            // Any press in this state is dropped, including one coinciding with the handshake.
            if (word_ready) begin
               byte_idx_d = '0;
               state_d    = COLLECT;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

endmodule

// File: tb/tb_dip_word_loader.sv
module tb_dip_word_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        btn;
   logic [7:0]  dip;
   logic        word_ready0, word_ready1;

   logic [7:0]  hex_val0, hex_val1;
   logic [1:0]  byte_idx0;
   logic [0:0]  byte_idx1;
   logic [15:0] word0;
   logic [7:0]  word1;
   logic        word_valid0, word_valid1;

   int vectors     = 0;
   int miscompares = 0;

   logic [31:0] sb0[$];
   logic [31:0] sb1[$];

   always #5 clk = ~clk;

   dip_word_loader #(.NBYTES(2), .DEBOUNCE_CYCLES(4)) u0 (
      .clk(clk), .rst(rst), .btn(btn), .dip(dip),
      .hex_val(hex_val0), .byte_idx(byte_idx0), .word(word0),
      .word_valid(word_valid0), .word_ready(word_ready0));

   dip_word_loader #(.NBYTES(1), .DEBOUNCE_CYCLES(4)) u1 (
      .clk(clk), .rst(rst), .btn(btn), .dip(dip),
      .hex_val(hex_val1), .byte_idx(byte_idx1), .word(word1),
      .word_valid(word_valid1), .word_ready(word_ready1));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_dip(input logic [7:0] v);
      dip = v;
      repeat (4) tick();
   endtask

   // Raise btn; the capture edge is the 7th edge after the rise.
   task automatic press_capture();
      btn = 1'b1;
      repeat (7) tick();
   endtask

   task automatic release_btn();
      btn = 1'b0;
      repeat (8) tick();
   endtask

   task automatic pop0(input string tag);
      logic [31:0] e;
      if (sb0.size() == 0) begin
         vectors++;
         miscompares++;
         $error("FAIL %s: observed word 0x%0h expected scoreboard entry (queue empty)", tag, word0);
      end else begin
         e = sb0.pop_front();
         check(tag, 32'(word0), e);
      end
   endtask

   task automatic pop1(input string tag);
      logic [31:0] e;
      if (sb1.size() == 0) begin
         vectors++;
         miscompares++;
         $error("FAIL %s: observed word 0x%0h expected scoreboard entry (queue empty)", tag, word1);
      end else begin
         e = sb1.pop_front();
         check(tag, 32'(word1), e);
      end
   endtask

   initial begin
      rst = 1'b1; btn = 1'b0; dip = 8'h00; word_ready0 = 1'b0; word_ready1 = 1'b0;
      #1;
      check("rst_word",  32'(word0), 'h0);
      check("rst_idx",   32'(byte_idx0), 'h0);
      check("rst_valid", 32'(word_valid0), 'h0);
      check("rst_hex",   32'(hex_val0), 'h0);
      #20 rst = 1'b0;
      repeat (2) tick();

      // Debounce rejection: toggle every 2 cycles for 40 cycles.
      dip = 8'h5A;
      for (int i = 0; i < 20; i++) begin
         btn = ~btn;
         repeat (2) tick();
         check("bounce_idx",  32'(byte_idx0), 'h0);
         check("bounce_word", 32'(word0), 'h0);
      end
      btn = 1'b0;
      repeat (8) tick();

      // Two-byte entry.
      set_dip(8'hA5);
      btn = 1'b1;
      repeat (6) tick();
      check("pre_capture_idx", 32'(byte_idx0), 'h0);
      tick();
      check("b1_word",  32'(word0), 'h00A5);
      check("b1_idx",   32'(byte_idx0), 'h1);
      check("b1_valid", 32'(word_valid0), 'h0);
      check("b1_hex",   32'(hex_val0), 'hA5);
      release_btn();
      set_dip(8'h3C);
      sb0.push_back('hA53C);
      press_capture();
      check("b2_word",  32'(word0), 'hA53C);
      check("b2_valid", 32'(word_valid0), 'h1);
      check("b2_hex",   32'(hex_val0), 'h3C);
      check("b2_idx",   32'(byte_idx0), 'h2);
      release_btn();

      // Backpressure: two presses while word_ready is low are dropped.
      set_dip(8'h77);
      for (int p = 0; p < 2; p++) begin
         btn = 1'b1;
         for (int c = 0; c < 15; c++) begin
            if (c == 7) btn = 1'b0;
            tick();
            check("bp_valid", 32'(word_valid0), 'h1);
            check("bp_word",  32'(word0), 'hA53C);
            check("bp_idx",   32'(byte_idx0), 'h2);
         end
      end

      // Handshake coincides with a press pulse: the press is dropped.
      btn = 1'b1;
      repeat (6) tick();
      word_ready0 = 1'b1;
      check("hs_valid", 32'(word_valid0), 'h1);
      pop0("hs_word_sb");
      tick();
      word_ready0 = 1'b0;
      check("post_hs_valid", 32'(word_valid0), 'h0);
      check("post_hs_idx",   32'(byte_idx0), 'h0);
      check("post_hs_word",  32'(word0), 'hA53C);
      check("post_hs_hex",   32'(hex_val0), 'h77);
      tick();
      check("collide_idx", 32'(byte_idx0), 'h0);
      release_btn();
      set_dip(8'h11);
      press_capture();
      check("c1_idx",  32'(byte_idx0), 'h1);
      check("c1_word", 32'(word0), 'h3C11);
      release_btn();

      // Asynchronous reset between clock edges, mid-entry.
      #2 rst = 1'b1;
      #1;
      check("arst_word",  32'(word0), 'h0);
      check("arst_idx",   32'(byte_idx0), 'h0);
      check("arst_valid", 32'(word_valid0), 'h0);
      check("arst_hex",   32'(hex_val0), 'h0);
      #3 rst = 1'b0;
      tick();
      set_dip(8'h01);
      press_capture();
      release_btn();
      set_dip(8'h02);
      sb0.push_back('h0102);
      press_capture();
      check("r_valid", 32'(word_valid0), 'h1);
      word_ready0 = 1'b1;
      pop0("r_word_sb");
      tick();
      word_ready0 = 1'b0;
      check("r_hs_valid", 32'(word_valid0), 'h0);
      release_btn();

      // NBYTES = 1 instance, from a clean reset.
      #2 rst = 1'b1;
      #4 rst = 1'b0;
      tick();
      set_dip(8'hFF);
      sb1.push_back('hFF);
      press_capture();
      check("n1_valid", 32'(word_valid1), 'h1);
      check("n1_word",  32'(word1), 'hFF);
      check("n1_hex",   32'(hex_val1), 'hFF);
      check("n1_idx",   32'(byte_idx1), 'h1);
      release_btn();
      set_dip(8'h5A);
      check("n1_hold_hex", 32'(hex_val1), 'hFF);
      word_ready1 = 1'b1;
      pop1("n1_word_sb");
      tick();
      word_ready1 = 1'b0;
      check("n1_hs_valid", 32'(word_valid1), 'h0);
      check("n1_echo_hex", 32'(hex_val1), 'h5A);
      check("n1_hs_idx",   32'(byte_idx1), 'h0);

      if (sb0.size() != 0 || sb1.size() != 0) begin
         vectors++;
         miscompares++;
         $error("FAIL sb_drain: observed %0d/%0d leftover entries expected 0/0", sb0.size(), sb1.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
